// File: rtl/trivium_stream_ctrl.sv
// trivium_stream_ctrl: sequences one trivium core and XORs its LSB-first keystream bytes onto a valid/ready byte stream
module trivium_stream_ctrl #(
  parameter int WARMUP_CYCLES = 1155,
  parameter int CNT_W         = 11
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       start,
  output logic       core_rst,
  output logic       core_enable,
  input  logic       core_ks_bit,
  input  logic [7:0] din,
  input  logic       din_valid,
  output logic       din_ready,
  output logic [7:0] dout,
  output logic       dout_valid,
  input  logic       dout_ready,
  output logic       busy,
  output logic       ks_ready
);
  typedef enum logic [1:0] {IDLE, LOAD, WARMUP, RUN} state_t;
  state_t           state, state_nx;
  logic [CNT_W-1:0] warm_cnt;
  logic [3:0]       issue_cnt;
  logic [2:0]       bit_cnt;
  logic [7:0]       ks_byte;
  logic             fresh, have_byte, warm_done, capture, accept;
  assign warm_done = warm_cnt == CNT_W'(WARMUP_CYCLES - 1);
  assign capture   = state == RUN && fresh && !start;
  assign accept    = din_valid && din_ready;
  assign busy      = state != IDLE;
  assign ks_ready  = state == RUN;
  assign din_ready = state == RUN && have_byte && (!dout_valid || dout_ready) && !start;
  // state register
  always_ff @(posedge clk or negedge rst)
    if (!rst) state <= IDLE;
    else state <= state_nx;
  // next state and core control; start from any state restarts at LOAD
  always_comb begin
    state_nx    = state;
    core_rst    = 1'b1;
    core_enable = 1'b0;
    case (state)
      IDLE: begin
        core_rst = 1'b0;
        state_nx = start ? LOAD : IDLE;
      end
      LOAD: begin
        core_rst = 1'b0;
        state_nx = start ? LOAD : WARMUP;
      end
      WARMUP: begin
        core_enable = 1'b1;
        state_nx    = start ? LOAD : (warm_done ? RUN : WARMUP);
      end
      default: begin
        core_enable = !have_byte && issue_cnt < 4'd8;
        state_nx    = start ? LOAD : RUN;
      end
    endcase
  end
  // warm-up count, bit capture into ks_byte and the output byte register;
  // the last warm-up edge already produced bit 0, so RUN starts with one bit issued
  always_ff @(posedge clk or negedge rst)
    if (!rst) begin
      warm_cnt   <= '0;
      issue_cnt  <= '0;
      bit_cnt    <= '0;
      ks_byte    <= '0;
      fresh      <= 1'b0;
      have_byte  <= 1'b0;
      dout       <= '0;
      dout_valid <= 1'b0;
    end else begin
      warm_cnt <= state == WARMUP ? warm_cnt + CNT_W'(1) : '0;
      fresh    <= start ? 1'b0 : core_enable;
      if (start) begin
        issue_cnt  <= '0;
        bit_cnt    <= '0;
        have_byte  <= 1'b0;
        dout_valid <= 1'b0;
      end else begin
        if (state == WARMUP && warm_done) begin
          issue_cnt <= 4'd1;
          bit_cnt   <= '0;
        end
        if (state == RUN && core_enable) issue_cnt <= issue_cnt + 4'd1;
        if (capture) begin
          ks_byte[bit_cnt] <= core_ks_bit;
          bit_cnt          <= bit_cnt + 3'd1;
          if (bit_cnt == 3'd7) begin
            have_byte <= 1'b1;
            issue_cnt <= '0;
          end
        end
        if (accept) begin
          dout       <= din ^ ks_byte;
          dout_valid <= 1'b1;
          have_byte  <= 1'b0;
        end else if (dout_ready) dout_valid <= 1'b0;
      end
    end
endmodule

// File: tb/tb_trivium_stream_ctrl.sv
// tb_trivium_stream_ctrl: randomized bench with a table-driven core and a timing/byte-order reference model
module tb_trivium_stream_ctrl;
  logic       clk = 1'b0, rst = 1'b0, start = 1'b0, din_valid = 1'b0, dout_ready = 1'b0;
  logic       core_rst, core_enable, core_ks_bit, din_ready, dout_valid, busy, ks_ready;
  logic [7:0] din = 8'h00, dout;

  trivium_stream_ctrl dut (
    .clk(clk), .rst(rst), .start(start), .core_rst(core_rst), .core_enable(core_enable),
    .core_ks_bit(core_ks_bit), .din(din), .din_valid(din_valid), .din_ready(din_ready),
    .dout(dout), .dout_valid(dout_valid), .dout_ready(dout_ready), .busy(busy), .ks_ready(ks_ready)
  );

  always #5 clk = ~clk;

  // core stand-in: output bit is a fixed random function of enabled edges since core reset
  logic ks_tab [4096];
  int   n = 0;
  always @(posedge clk) begin
    if (!core_rst) n <= 0;
    else if (core_enable && n < 4095) n <= n + 1;
  end
  assign core_ks_bit = ks_tab[n];

  // keystream byte k = core bits 1155+8k .. 1155+8k+7, LSB first
  function automatic logic [7:0] ks_at(input int k);
    logic [7:0] b;
    for (int i = 0; i < 8; i++) b[i] = ks_tab[1155 + 8 * k + i];
    return b;
  endfunction

  int         tests = 0, fails = 0;
  int         cyc = 0, t_start = 0, kidx = 0, avail = 0;
  bit         started = 0, mv = 0;
  logic [7:0] md = 8'h00;
  logic       e_ready, e_valid, e_busy, e_ks, e_crst;
  logic [7:0] e_dout;

  // drive one cycle, derive expected outputs, then advance the model across the coming edge
  task automatic tick(input logic s, input logic v, input logic [7:0] d, input logic r);
    @(negedge clk);
    start = s; din_valid = v; din = d; dout_ready = r;
    cyc++;
    #1;
    e_busy  = started;
    e_ks    = started && (cyc - t_start >= 1157);
    e_crst  = started && (cyc - t_start >= 2);
    e_valid = mv;
    e_dout  = md;
    e_ready = e_ks && cyc >= avail && (!mv || r) && !s;
    if (s) begin
      started = 1; t_start = cyc; kidx = 0; mv = 0; avail = cyc + 1165;
    end else if (e_ready && v) begin
      mv = 1; md = d ^ ks_at(kidx); kidx++; avail = cyc + 10;
    end else if (mv && r) mv = 0;
  endtask

  task automatic model_reset();
    started = 0; mv = 0; md = 8'h00;
  endtask

  task automatic test_reset();
    @(negedge clk);
    rst = 1'b0;
    #1;
    tests++; if (core_rst !== 1'b0) begin fails++; $display("FAIL reset core_rst got=%b exp=0", core_rst); end
    tests++; if (core_enable !== 1'b0) begin fails++; $display("FAIL reset core_enable got=%b exp=0", core_enable); end
    tests++; if (dout !== 8'h00) begin fails++; $display("FAIL reset dout got=%h exp=00", dout); end
    tests++; if (dout_valid !== 1'b0) begin fails++; $display("FAIL reset dout_valid got=%b exp=0", dout_valid); end
    tests++; if (din_ready !== 1'b0) begin fails++; $display("FAIL reset din_ready got=%b exp=0", din_ready); end
    tests++; if ({busy, ks_ready} !== 2'b00) begin fails++; $display("FAIL reset busy/ks_ready got=%b exp=00", {busy, ks_ready}); end
    model_reset();
    @(negedge clk);
    rst = 1'b1;
  endtask

  task automatic test_warmup();
    int en_cnt = 0;
    tick(1, 0, 8'h00, 0);
    for (int i = 0; i < 1200; i++) begin
      tick(0, 0, 8'h00, 0);
      if (cyc - t_start <= 1156 && core_enable === 1'b1) en_cnt++;
      tests++; if (ks_ready !== e_ks) begin fails++; $display("FAIL warmup ks_ready off=%0d got=%b exp=%b", cyc - t_start, ks_ready, e_ks); end
      tests++; if (busy !== e_busy) begin fails++; $display("FAIL warmup busy off=%0d got=%b exp=%b", cyc - t_start, busy, e_busy); end
      tests++; if (core_rst !== e_crst) begin fails++; $display("FAIL warmup core_rst off=%0d got=%b exp=%b", cyc - t_start, core_rst, e_crst); end
    end
    tests++; if (en_cnt != 1155) begin fails++; $display("FAIL warmup enable_count got=%0d exp=1155", en_cnt); end
  endtask

  task automatic test_first_bytes();
    for (int i = 0; i < 100 && kidx < 4; i++) begin
      tick(0, 1, 8'h00, 1);
      tests++; if (din_ready !== e_ready) begin fails++; $display("FAIL first din_ready cyc=%0d got=%b exp=%b", cyc, din_ready, e_ready); end
      tests++; if (dout_valid !== e_valid) begin fails++; $display("FAIL first dout_valid cyc=%0d got=%b exp=%b", cyc, dout_valid, e_valid); end
      if (e_valid) begin tests++; if (dout !== e_dout) begin fails++; $display("FAIL first dout cyc=%0d got=%h exp=%h", cyc, dout, e_dout); end end
    end
    tick(0, 0, 8'h00, 1);
    tests++; if (dout !== ks_at(3)) begin fails++; $display("FAIL first byte3 got=%h exp=%h", dout, ks_at(3)); end
    tests++; if (kidx != 4) begin fails++; $display("FAIL first timeout bytes=%0d exp=4", kidx); end
  endtask

  task automatic test_stream_ff();
    int target = kidx + 16, pulses = 0;
    for (int i = 0; i < 200 && kidx < target; i++) begin
      tick(0, 1, 8'hff, 1);
      if (din_ready === 1'b1) pulses++;
      tests++; if (din_ready !== e_ready) begin fails++; $display("FAIL stream din_ready cyc=%0d got=%b exp=%b", cyc, din_ready, e_ready); end
      tests++; if (dout_valid !== e_valid) begin fails++; $display("FAIL stream dout_valid cyc=%0d got=%b exp=%b", cyc, dout_valid, e_valid); end
      if (e_valid) begin tests++; if (dout !== e_dout) begin fails++; $display("FAIL stream dout cyc=%0d got=%h exp=%h", cyc, dout, e_dout); end end
    end
    tests++; if (pulses != 16) begin fails++; $display("FAIL stream din_ready_pulses got=%0d exp=16", pulses); end
  endtask

  task automatic test_backpressure();
    logic [7:0] held;
    for (int i = 0; i < 40 && !mv; i++) tick(0, 1, 8'($urandom), 1);
    held = md;
    for (int i = 0; i < 30; i++) begin
      tick(0, 1, 8'($urandom), 0);
      tests++; if (dout_valid !== 1'b1 || dout !== held) begin fails++; $display("FAIL stall dout i=%0d got=%b/%h exp=1/%h", i, dout_valid, dout, held); end
      tests++; if (din_ready !== 1'b0) begin fails++; $display("FAIL stall din_ready i=%0d got=%b exp=0", i, din_ready); end
      if (i >= 12) begin tests++; if (core_enable !== 1'b0) begin fails++; $display("FAIL stall core_enable i=%0d got=%b exp=0", i, core_enable); end end
    end
    for (int i = 0; i < 80; i++) begin
      tick(0, 1, 8'($urandom), 1'($urandom));
      tests++; if (din_ready !== e_ready) begin fails++; $display("FAIL resume din_ready cyc=%0d got=%b exp=%b", cyc, din_ready, e_ready); end
      tests++; if (dout_valid !== e_valid) begin fails++; $display("FAIL resume dout_valid cyc=%0d got=%b exp=%b", cyc, dout_valid, e_valid); end
      if (e_valid) begin tests++; if (dout !== e_dout) begin fails++; $display("FAIL resume dout cyc=%0d got=%h exp=%h", cyc, dout, e_dout); end end
    end
  endtask

  task automatic test_restart();
    int target = kidx + 5;
    for (int i = 0; i < 100 && kidx < target; i++) tick(0, 1, 8'($urandom), 1);
    tests++; if (kidx != target) begin fails++; $display("FAIL restart timeout bytes=%0d exp=%0d", kidx, target); end
    tick(1, 1, 8'h5a, 0);
    tests++; if (din_ready !== 1'b0) begin fails++; $display("FAIL restart din_ready_with_start got=%b exp=0", din_ready); end
    tick(0, 1, 8'h5a, 0);
    tests++; if (core_rst !== 1'b0) begin fails++; $display("FAIL restart core_rst_load got=%b exp=0", core_rst); end
    tests++; if (dout_valid !== 1'b0) begin fails++; $display("FAIL restart dout_valid got=%b exp=0", dout_valid); end
    tick(0, 1, 8'h5a, 0);
    tests++; if (core_rst !== 1'b1) begin fails++; $display("FAIL restart core_rst_warm got=%b exp=1", core_rst); end
    for (int i = 0; i < 1200; i++) begin
      tick(0, 1, 8'($urandom), 1);
      tests++; if (din_ready !== e_ready) begin fails++; $display("FAIL restart din_ready cyc=%0d got=%b exp=%b", cyc, din_ready, e_ready); end
      tests++; if (dout_valid !== e_valid) begin fails++; $display("FAIL restart dout_valid cyc=%0d got=%b exp=%b", cyc, dout_valid, e_valid); end
      if (e_valid) begin tests++; if (dout !== e_dout) begin fails++; $display("FAIL restart dout cyc=%0d got=%h exp=%h", cyc, dout, e_dout); end end
    end
  endtask

  task automatic test_rst_async();
    tick(1, 0, 8'h00, 0);
    for (int i = 0; i < 300; i++) tick(0, 0, 8'h00, 0);
    #2 rst = 1'b0;
    #1;
    tests++; if ({core_rst, core_enable, busy, ks_ready} !== 4'b0000) begin fails++; $display("FAIL rst_warm ctrl got=%b exp=0000", {core_rst, core_enable, busy, ks_ready}); end
    model_reset();
    @(negedge clk);
    rst = 1'b1;
    for (int i = 0; i < 5; i++) begin
      tick(0, 1, 8'h00, 1);
      tests++; if ({busy, core_rst, din_ready} !== 3'b000) begin fails++; $display("FAIL rst_idle got=%b exp=000", {busy, core_rst, din_ready}); end
    end
    tick(1, 0, 8'h00, 0);
    for (int i = 0; i < 1200 && !mv; i++) tick(0, 1, 8'($urandom), 0);
    tick(0, 0, 8'h00, 0);
    tests++; if (dout_valid !== 1'b1) begin fails++; $display("FAIL rst_run precondition dout_valid got=%b exp=1", dout_valid); end
    #2 rst = 1'b0;
    #1;
    tests++; if ({dout_valid, din_ready, core_rst, core_enable, busy, ks_ready} !== 6'b0) begin fails++; $display("FAIL rst_run ctrl got=%b exp=000000", {dout_valid, din_ready, core_rst, core_enable, busy, ks_ready}); end
    tests++; if (dout !== 8'h00) begin fails++; $display("FAIL rst_run dout got=%h exp=00", dout); end
    model_reset();
    @(negedge clk);
    rst = 1'b1;
  endtask

  task automatic test_random();
    tick(1, 0, 8'h00, 0);
    for (int i = 0; i < 2500; i++) begin
      tick(1'($urandom_range(0, 999) == 0), 1'($urandom), 8'($urandom), 1'($urandom));
      tests++; if (din_ready !== e_ready) begin fails++; $display("FAIL random din_ready cyc=%0d got=%b exp=%b", cyc, din_ready, e_ready); end
      tests++; if (dout_valid !== e_valid) begin fails++; $display("FAIL random dout_valid cyc=%0d got=%b exp=%b", cyc, dout_valid, e_valid); end
      tests++; if (ks_ready !== e_ks) begin fails++; $display("FAIL random ks_ready cyc=%0d got=%b exp=%b", cyc, ks_ready, e_ks); end
      if (e_valid) begin tests++; if (dout !== e_dout) begin fails++; $display("FAIL random dout cyc=%0d got=%h exp=%h", cyc, dout, e_dout); end end
    end
  endtask

  initial begin
    for (int i = 0; i < 4096; i++) ks_tab[i] = 1'($urandom);
    test_reset();
    test_warmup();
    test_first_bytes();
    test_stream_ff();
    test_backpressure();
    test_restart();
    test_rst_async();
    test_random();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
